timer_mc: RTL

- Parametrised multi-channel count-up timer; successor to the single-channel 32-bit peripheral timer on the core's peripheral bus.
- NUM_CH independent channels, each with:
  - one-shot or periodic (auto-reload) mode
  - per-channel interrupt enable and W1C pending bit
  - optional clock prescaler
- All channel interrupts are ORed onto one interrupt line to the core.

---
 rtl/timer_mc.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/timer_mc.sv
// timer_mc: multi-channel count-up timer on the peripheral bus.
// Each channel has one-shot/periodic mode, an interrupt enable and a W1C
// pending bit. All channel interrupts are ORed onto int_sig_o.
// Optional per-channel prescaler is built when TIMER_MC_PRESCALER_EN is defined;
// without it every cycle of an active channel is a tick and offset 0xC reads 0.
module timer_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic        req_i,
  output logic [31:0] data_o,
  output logic        int_sig_o,
  output logic        ack_o
);

  localparam int unsigned AW         = 4;
  localparam logic [3:0]  OFF_CTRL   = 4'h0;
  localparam logic [3:0]  OFF_COUNT  = 4'h4;
  localparam logic [3:0]  OFF_VALUE  = 4'h8;
  localparam logic [3:0]  SEL_GLOBAL = 4'hF;
`ifdef TIMER_MC_PRESCALER_EN
  localparam logic [3:0]  OFF_PRESC  = 4'hC;
`endif

  logic [AW-1:0] sel_ch;
  logic [AW-1:0] sel_off;
  logic          wr;

  assign sel_ch  = addr_i[7:4];
  assign sel_off = addr_i[3:0];
  assign wr      = req_i & we_i;

  // Per-channel architectural state
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] int_en_q, int_en_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [WIDTH-1:0]  count_q [NUM_CH];
  logic [WIDTH-1:0]  count_d [NUM_CH];
  logic [WIDTH-1:0]  value_q [NUM_CH];
  logic [WIDTH-1:0]  value_d [NUM_CH];
`ifdef TIMER_MC_PRESCALER_EN
  logic [PRESC_WIDTH-1:0] presc_q [NUM_CH];
  logic [PRESC_WIDTH-1:0] presc_d [NUM_CH];
  logic [PRESC_WIDTH-1:0] pcnt_q  [NUM_CH];
  logic [PRESC_WIDTH-1:0] pcnt_d  [NUM_CH];
  logic [NUM_CH-1:0]      wr_presc;
`else
  logic [PRESC_WIDTH-1:0] unused_presc;
  assign unused_presc = data_i[PRESC_WIDTH-1:0];
`endif

  logic [NUM_CH-1:0] wr_ctrl, wr_value, restart;
  logic [NUM_CH-1:0] active, tick, expire;
  logic              ack_q, int_q;

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:8], data_i};

  // Address decode of write strobes and period-restart conditions
  always_comb begin
    wr_ctrl  = '0;
    wr_value = '0;
    restart  = '0;
`ifdef TIMER_MC_PRESCALER_EN
    wr_presc = '0;
`endif
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr && (sel_ch == AW'(i))) begin
        wr_ctrl[i]  = (sel_off == OFF_CTRL);
        wr_value[i] = (sel_off == OFF_VALUE);
`ifdef TIMER_MC_PRESCALER_EN
        wr_presc[i] = (sel_off == OFF_PRESC);
`endif
      end
`ifdef TIMER_MC_PRESCALER_EN
      restart[i] = wr_value[i] | wr_presc[i] | (wr_ctrl[i] & ~data_i[0]);
`else
      restart[i] = wr_value[i] | (wr_ctrl[i] & ~data_i[0]);
`endif
    end
  end

  // Tick and expiry detection per channel
  always_comb begin
    active = '0;
    tick   = '0;
    expire = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      active[i] = en_q[i] && (value_q[i] != '0);
`ifdef TIMER_MC_PRESCALER_EN
      tick[i]   = active[i] && (pcnt_q[i] == presc_q[i]);
`else
      tick[i]   = active[i];
`endif
      // >= rather than == so a VALUE lowered below COUNT expires on the next tick
      expire[i] = tick[i] && (count_q[i] >= (value_q[i] - WIDTH'(1)));
    end
  end

  // Next-state logic: bus writes, counting, expiry; expiry beats W1C
  always_comb begin
    en_d      = en_q;
    int_en_d  = int_en_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      count_d[i] = count_q[i];
      value_d[i] = value_q[i];
`ifdef TIMER_MC_PRESCALER_EN
      presc_d[i] = presc_q[i];
      pcnt_d[i]  = pcnt_q[i];
`endif
      if (wr_ctrl[i]) begin
        en_d[i]     = data_i[0];
        int_en_d[i] = data_i[1];
        mode_d[i]   = data_i[3];
      end else if (expire[i] && !mode_q[i]) begin
        en_d[i] = 1'b0;
      end

      if (expire[i]) begin
        pending_d[i] = 1'b1;
      end else if (wr_ctrl[i] && data_i[2]) begin
        pending_d[i] = 1'b0;
      end

      if (wr_value[i]) begin
        value_d[i] = data_i[WIDTH-1:0];
      end

      if (restart[i] || !active[i]) begin
        count_d[i] = '0;
      end else if (tick[i]) begin
        count_d[i] = expire[i] ? '0 : count_q[i] + WIDTH'(1);
      end

`ifdef TIMER_MC_PRESCALER_EN
      if (wr_presc[i]) begin
        presc_d[i] = data_i[PRESC_WIDTH-1:0];
      end
      if (restart[i] || !active[i] || tick[i]) begin
        pcnt_d[i] = '0;
      end else begin
        pcnt_d[i] = pcnt_q[i] + PRESC_WIDTH'(1);
      end
`endif
    end
  end

  // State registers, interrupt and ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q      <= '0;
      int_en_q  <= '0;
      pending_q <= '0;
      mode_q    <= '0;
      ack_q     <= 1'b0;
      int_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count_q[i] <= '0;
        value_q[i] <= '0;
`ifdef TIMER_MC_PRESCALER_EN
        presc_q[i] <= '0;
        pcnt_q[i]  <= '0;
`endif
      end
    end else begin
      en_q      <= en_d;
      int_en_q  <= int_en_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      ack_q     <= req_i;
      int_q     <= |(pending_q & int_en_q);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count_q[i] <= count_d[i];
        value_q[i] <= value_d[i];
`ifdef TIMER_MC_PRESCALER_EN
        presc_q[i] <= presc_d[i];
        pcnt_q[i]  <= pcnt_d[i];
`endif
      end
    end
  end

  assign ack_o     = ack_q;
  assign int_sig_o = int_q;

  // Combinational read mux; forced to 0 while in reset
  always_comb begin
    data_o = '0;
    if (rst) begin
      if (sel_ch == SEL_GLOBAL) begin
        if (sel_off == OFF_CTRL) begin
          data_o = 32'(pending_q);
        end
      end else begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (sel_ch == AW'(i)) begin
            case (sel_off)
              OFF_CTRL:  data_o = {28'd0, mode_q[i], pending_q[i], int_en_q[i], en_q[i]};
              OFF_COUNT: data_o = 32'(count_q[i]);
              OFF_VALUE: data_o = 32'(value_q[i]);
`ifdef TIMER_MC_PRESCALER_EN
              OFF_PRESC: data_o = 32'(presc_q[i]);
`endif
              default:   data_o = '0;
            endcase
          end
        end
      end
    end
  end

endmodule
